hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage CPU: tracks destination registers of in-flight instructions, generates the registered bypass selects (byp0_EX/byp0_DM/byp1_EX/byp1_DM) and LWI_instr_EX_DM consumed by src_mux, and produces per-stage stall, bubble and flush controls. It sits beside the ID stage: it takes decoded register addresses from ID, plus the memory-stall and branch-flush events, and drives every pipeline-register enable.

---
 rtl/hazard_ctrl_if.sv | 19 +
 rtl/hazard_ctrl.sv | 66 ++++++
 tb/tb_hazard_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-side decode inputs and pipeline control outputs of the hazard controller
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0] p0_addr, p1_addr, dst_addr_ID, dst_addr_DM_WB;
  logic re0, re1, we_ID, ld_ID, lwi_ID, dm_stall, flush;
  logic stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB;
  logic bubble_ID_EX, flush_IF_ID, byp0_EX, byp0_DM, byp1_EX, byp1_DM;
  logic LWI_instr_EX_DM, we_DM_WB;
  logic [CNT_W-1:0] stall_cnt;
  modport master(
    output p0_addr, p1_addr, re0, re1, dst_addr_ID, we_ID, ld_ID, lwi_ID, dm_stall, flush,
    input stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX, flush_IF_ID,
    input byp0_EX, byp0_DM, byp1_EX, byp1_DM, LWI_instr_EX_DM, dst_addr_DM_WB, we_DM_WB, stall_cnt
  );
  modport slave(
    input p0_addr, p1_addr, re0, re1, dst_addr_ID, we_ID, ld_ID, lwi_ID, dm_stall, flush,
    output stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX, flush_IF_ID,
    output byp0_EX, byp0_DM, byp1_EX, byp1_DM, LWI_instr_EX_DM, dst_addr_DM_WB, we_DM_WB, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight destinations, drives bypass selects, load-use stall, flush and pipeline holds
module hazard_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  typedef struct packed {
    logic [AW-1:0] dst;
    logic we, ld, lwi;
  } ent_t;
  typedef enum logic {RUN, LDUSE} state_t;
  state_t state, state_nx;
  ent_t id_ent, id_ex, ex_dm, dm_wb;
  logic [3:0] byp;
  logic [CNT_W-1:0] cnt;
  logic h0e, h1e, h0d, h1d, lu, lu_stall, bub;
  function automatic logic hit(input logic re, input logic [AW-1:0] a, input ent_t e);
    return re & e.we & (e.dst == a) & (a != '0);
  endfunction
  always_comb begin
    id_ent = '{dst: bus.dst_addr_ID, we: bus.we_ID, ld: bus.ld_ID, lwi: bus.lwi_ID};
    h0e = hit(bus.re0, bus.p0_addr, id_ex);
    h1e = hit(bus.re1, bus.p1_addr, id_ex);
    h0d = hit(bus.re0, bus.p0_addr, ex_dm);
    h1d = hit(bus.re1, bus.p1_addr, ex_dm);
    lu = (h0e | h1e) & id_ex.ld;
    lu_stall = (state == RUN) & lu & ~bus.flush & ~bus.dm_stall;
    bub = ~bus.dm_stall & (bus.flush | lu_stall);
    state_nx = bus.dm_stall ? state : (bus.flush ? RUN : (lu_stall ? LDUSE : RUN));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      id_ex <= '0;
      ex_dm <= '0;
      dm_wb <= '0;
      byp <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (!bus.dm_stall) begin
        id_ex <= bub ? '0 : id_ent;
        ex_dm <= id_ex;
        dm_wb <= ex_dm;
        byp <= bub ? '0 : {h0e, h0d & ~h0e, h1e, h1d & ~h1e};
      end
      if (bus.stall_PC && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
  assign bus.stall_PC = bus.dm_stall | lu_stall;
  assign bus.stall_IF_ID = bus.dm_stall | lu_stall;
  assign bus.stall_ID_EX = bus.dm_stall;
  assign bus.stall_EX_DM = bus.dm_stall;
  assign bus.stall_DM_WB = bus.dm_stall;
  assign bus.bubble_ID_EX = bub;
  assign bus.flush_IF_ID = ~bus.dm_stall & bus.flush;
  assign {bus.byp0_EX, bus.byp0_DM, bus.byp1_EX, bus.byp1_DM} = byp;
  assign bus.LWI_instr_EX_DM = ex_dm.lwi;
  assign bus.dst_addr_DM_WB = dm_wb.dst;
  assign bus.we_DM_WB = dm_wb.we;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed instruction sequences with a bypass scoreboard and control checks
module tb_hazard_ctrl;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(16)) bus();
  hazard_ctrl #(.NUM_REGS(16), .CNT_W(16)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0, n_fail = 0;
  logic [3:0] sb[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ins(input logic [3:0] dst, input logic we, input logic ld, input logic lwi,
                     input logic [3:0] a0, input logic r0, input logic [3:0] a1, input logic r1);
    bus.dst_addr_ID = dst; bus.we_ID = we; bus.ld_ID = ld; bus.lwi_ID = lwi;
    bus.p0_addr = a0; bus.re0 = r0; bus.p1_addr = a1; bus.re1 = r1;
    #1;
  endtask
  task automatic nop();
    ins(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cyc(input string tag, input logic [3:0] e);
    logic [3:0] x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk(tag, {bus.byp0_EX, bus.byp0_DM, bus.byp1_EX, bus.byp1_DM}, x);
  endtask
  task automatic ctl(input string tag, input logic [6:0] e);
    #1;
    chk(tag, {bus.stall_PC, bus.stall_IF_ID, bus.stall_ID_EX, bus.stall_EX_DM, bus.stall_DM_WB,
              bus.bubble_ID_EX, bus.flush_IF_ID}, e);
  endtask
  task automatic regs(input string tag, input logic [5:0] e);
    chk(tag, {bus.LWI_instr_EX_DM, bus.we_DM_WB, bus.dst_addr_DM_WB}, e);
  endtask
  initial begin
    bus.dm_stall = 1; bus.flush = 1;
    nop();
    cyc("rst0", 0);
    cyc("rst1", 0);
    regs("rst_regs", 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    rst_n = 1; bus.dm_stall = 0; bus.flush = 0;
    ins(3, 1, 0, 0, 0, 0, 0, 0); cyc("a_add", 0);
    ins(7, 1, 0, 0, 3, 1, 0, 0); ctl("a_ctl", 0); cyc("a_byp", 4'b1000);
    ins(3, 1, 0, 0, 0, 0, 0, 0); cyc("b_add", 0);
    nop(); cyc("b_nop", 0);
    ins(4, 1, 0, 0, 0, 0, 3, 1); cyc("b_dm", 4'b0001);
    ins(3, 1, 0, 0, 0, 0, 0, 0); cyc("b_add1", 0);
    ins(3, 1, 0, 0, 0, 0, 0, 0); cyc("b_add2", 0);
    ins(0, 0, 0, 0, 0, 0, 3, 1); cyc("b_ex", 4'b0010);
    regs("b_wb", 6'h13);
    ins(0, 1, 1, 0, 0, 0, 0, 0); cyc("r0_lw", 0);
    ins(5, 1, 0, 0, 0, 1, 0, 1); ctl("r0_ctl", 0); cyc("r0_byp", 0);
    ins(5, 1, 1, 0, 0, 0, 0, 0); cyc("lu_lw", 0);
    ins(6, 1, 0, 0, 5, 1, 0, 0); ctl("lu_ctl", 7'b1100010); cyc("lu_bub", 0);
    ctl("lu_ldu", 0); cyc("lu_dm", 4'b0100);
    chk("lu_cnt", bus.stall_cnt, 1);
    ins(5, 1, 1, 0, 0, 0, 0, 0); cyc("bb_lw5", 0);
    ins(6, 1, 1, 0, 5, 1, 0, 0); ctl("bb_ctl1", 7'b1100010); cyc("bb_bub1", 0);
    ctl("bb_ldu1", 0); cyc("bb_dm1", 4'b0100);
    ins(7, 1, 0, 0, 0, 0, 6, 1); ctl("bb_ctl2", 7'b1100010); cyc("bb_bub2", 0);
    ctl("bb_ldu2", 0); cyc("bb_dm2", 4'b0001);
    chk("bb_cnt", bus.stall_cnt, 3);
    ins(5, 1, 1, 0, 0, 0, 0, 0); cyc("ds_lw", 0);
    ins(8, 1, 0, 0, 5, 1, 0, 0); ctl("ds_lu", 7'b1100010); cyc("ds_bub", 0);
    bus.dm_stall = 1; ctl("ds_ctl", 7'b1111100);
    for (int i = 0; i < 3; i++) cyc("ds_hold", 0);
    bus.dm_stall = 0; ctl("ds_ldu", 0); cyc("ds_done", 4'b0100);
    chk("ds_cnt", bus.stall_cnt, 7);
    nop(); bus.dm_stall = 1; cyc("ds_byp_hold", 4'b0100);
    bus.dm_stall = 0; cyc("ds_after", 0);
    chk("ds_cnt2", bus.stall_cnt, 8);
    ins(5, 1, 1, 0, 0, 0, 0, 0); cyc("fl_lw", 0);
    ins(9, 1, 0, 0, 5, 1, 0, 0); bus.flush = 1; ctl("fl_ctl", 7'b0000011); cyc("fl_bub", 0);
    bus.flush = 0; ctl("fl_run", 0);
    chk("fl_cnt", bus.stall_cnt, 8);
    ins(5, 1, 1, 0, 0, 0, 0, 0); cyc("rs_lw", 0);
    ins(9, 1, 0, 0, 5, 1, 0, 0); bus.dm_stall = 1; ctl("rs_ctl", 7'b1111100);
    rst_n = 0; cyc("rs_rst", 0);
    rst_n = 1; bus.dm_stall = 0; nop(); ctl("rs_ctl2", 0);
    regs("rs_regs", 0);
    chk("rs_cnt", bus.stall_cnt, 0);
    ins(2, 1, 0, 1, 0, 0, 0, 0); cyc("lwi_id", 0);
    nop(); cyc("lwi_ex", 0);
    regs("lwi_exdm", 6'h20);
    cyc("lwi_dm", 0);
    regs("lwi_wb", 6'h12);
    bus.dm_stall = 1;
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", bus.stall_cnt, 16'hFFFE);
    @(posedge clk);
    #1 chk("sat_ffff", bus.stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1 chk("sat_hold", bus.stall_cnt, 16'hFFFF);
    bus.dm_stall = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
